// File: rtl/bonus_ship_pkg.sv
// Bonus ship shared types and default geometry/timing.
// Holds the FSM state enum and the default parameter values.
package bonus_ship_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLYING = 2'd1,
        ST_HIT    = 2'd2
    } state_t;

    localparam int SHIP_WIDTH_D   = 64;
    localparam int SHIP_HEIGHT_D  = 32;
    localparam int TOP_Y_D        = 40;
    localparam int SCREEN_WIDTH_D = 640;
    localparam int SPAWN_FRAMES_D = 600;
    localparam int SPEED_D        = 2;
    localparam int HIT_FRAMES_D   = 30;

    localparam int CNT_W = 16;

endpackage

// File: rtl/bonus_ship_controller_if.sv
// Bonus ship bus: scan position, frame/game/collision inputs and draw outputs.
// slave = controller side, master = driver/observer side.
interface bonus_ship_if;

    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        playGame;
    logic        collision;
    logic        InsideRectangle;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        bonusHit;
    logic        shipActive;

    modport slave (
        input  pixelX, pixelY, startOfFrame, playGame, collision,
        output InsideRectangle, offsetX, offsetY, bonusHit, shipActive
    );

    modport master (
        output pixelX, pixelY, startOfFrame, playGame, collision,
        input  InsideRectangle, offsetX, offsetY, bonusHit, shipActive
    );

endinterface

// File: rtl/bonus_frame_timer.sv
// Frame counter: counts i_sof while enabled, o_done on the terminal pulse.
// Ports: clk, resetN, i_sof, i_en, i_clear, i_term (terminal count), o_done.
module bonus_frame_timer
    import bonus_ship_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             i_sof,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;
    logic             w_done;

    // done fires on the pulse that would bring the count up to i_term
    assign w_done = i_en && i_sof && (r_count == i_term - 1'b1);
    assign o_done = w_done;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_clear || w_done) begin
            r_count <= '0;
        end else if (i_en && i_sof) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/bonus_ship_controller.sv
// Bonus ship: spawns after an idle delay, crosses the screen, can be shot.
// Ports: clk, resetN, bus (bonus_ship_if.slave: scan/frame inputs, draw outputs).
module bonus_ship_controller
    import bonus_ship_pkg::*;
#(
    parameter int SHIP_WIDTH   = SHIP_WIDTH_D,
    parameter int SHIP_HEIGHT  = SHIP_HEIGHT_D,
    parameter int TOP_Y        = TOP_Y_D,
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_D,
    parameter int SPAWN_FRAMES = SPAWN_FRAMES_D,
    parameter int SPEED        = SPEED_D,
    parameter int HIT_FRAMES   = HIT_FRAMES_D
)(
    input  logic         clk,
    input  logic         resetN,
    bonus_ship_if.slave  bus
);

    localparam logic signed [11:0] C_LEFT  = 12'(-SHIP_WIDTH);
    localparam logic signed [11:0] C_RIGHT = 12'(SCREEN_WIDTH);
    localparam logic signed [11:0] C_SPEED = 12'(SPEED);

    state_t                r_state;
    logic signed [11:0]    r_pos;
    logic                  r_rtl;
    logic                  r_next_rtl;
    logic                  r_hit;
    logic                  r_active;

    logic                  w_done;
    logic                  w_clear;
    logic                  w_en;
    logic [CNT_W-1:0]      w_term;
    logic signed [11:0]    w_next_pos;
    logic                  w_exit;
    logic signed [12:0]    w_px;
    logic signed [12:0]    w_left;
    logic signed [12:0]    w_right;
    logic [11:0]           w_py;
    logic                  w_in_x;
    logic                  w_in_y;

    // counter idles at zero in flight, so HIT always starts from a clean count
    assign w_en    = (r_state != ST_FLYING);
    assign w_clear = !bus.playGame || (r_state == ST_FLYING);
    assign w_term  = (r_state == ST_HIT) ? CNT_W'(HIT_FRAMES)
                                         : CNT_W'(SPAWN_FRAMES);

    bonus_frame_timer u_timer (
        .clk     (clk),
        .resetN  (resetN),
        .i_sof   (bus.startOfFrame),
        .i_en    (w_en),
        .i_clear (w_clear),
        .i_term  (w_term),
        .o_done  (w_done)
    );

    assign w_next_pos = r_rtl ? (r_pos - C_SPEED) : (r_pos + C_SPEED);
    assign w_exit     = r_rtl ? (w_next_pos <= C_LEFT)
                              : (w_next_pos >= C_RIGHT);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_IDLE;
            r_pos      <= '0;
            r_rtl      <= 1'b0;
            r_next_rtl <= 1'b0;
            r_hit      <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (!bus.playGame) begin
                r_state    <= ST_IDLE;
                r_active   <= 1'b0;
                r_next_rtl <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_done) begin
                            r_state    <= ST_FLYING;
                            r_active   <= 1'b1;
                            r_rtl      <= r_next_rtl;
                            r_next_rtl <= !r_next_rtl;
                            r_pos      <= r_next_rtl ? C_RIGHT : C_LEFT;
                        end
                    end
                    ST_FLYING: begin
                        // collision beats a coincident frame move
                        if (bus.collision) begin
                            r_state  <= ST_HIT;
                            r_active <= 1'b0;
                            r_hit    <= 1'b1;
                        end else if (bus.startOfFrame) begin
                            r_pos <= w_next_pos;
                            if (w_exit) begin
                                r_state  <= ST_IDLE;
                                r_active <= 1'b0;
                            end
                        end
                    end
                    ST_HIT: begin
                        if (w_done) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    // 13-bit signed compare keeps off-screen left edges correct
    assign w_px    = $signed({2'b00, bus.pixelX});
    assign w_left  = {r_pos[11], r_pos};
    assign w_right = w_left + 13'(SHIP_WIDTH);
    assign w_py    = {1'b0, bus.pixelY};
    assign w_in_x  = (w_px >= w_left) && (w_px < w_right);
    assign w_in_y  = (w_py >= 12'(TOP_Y))
                  && (w_py < 12'(TOP_Y + SHIP_HEIGHT));

    assign bus.InsideRectangle = r_active && w_in_x && w_in_y;
    assign bus.offsetX         = bus.pixelX - r_pos[10:0];
    assign bus.offsetY         = bus.pixelY - 11'(TOP_Y);
    assign bus.bonusHit        = r_hit;
    assign bus.shipActive      = r_active;

endmodule

// File: tb/tb_bonus_ship_controller.sv
// Self-checking bench for bonus_ship_controller.
// Frame-level model checked every cycle plus directed literal probes.
module tb_bonus_ship_controller;

    localparam int W   = 64;
    localparam int H   = 32;
    localparam int TY  = 40;
    localparam int SCR = 640;
    localparam int SPN = 600;
    localparam int SPD = 2;
    localparam int HF  = 30;

    logic clk;
    logic resetN;
    bonus_ship_if bus();

    bonus_ship_controller #(
        .SHIP_WIDTH   (W),
        .SHIP_HEIGHT  (H),
        .TOP_Y        (TY),
        .SCREEN_WIDTH (SCR),
        .SPAWN_FRAMES (SPN),
        .SPEED        (SPD),
        .HIT_FRAMES   (HF)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_bonus  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: 0 idle, 1 flying, 2 hit
    int m_mode, m_frames, m_x;
    bit m_ltr, m_next_ltr, m_bonus;
    int m_nx;
    bit m_inside;

    assign m_nx = m_ltr ? m_x + SPD : m_x - SPD;
    assign m_inside = (m_mode == 1)
        && (int'(bus.pixelX) >= m_x) && (int'(bus.pixelX) < m_x + W)
        && (int'(bus.pixelY) >= TY) && (int'(bus.pixelY) < TY + H);

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_mode <= 0; m_frames <= 0; m_x <= 0;
            m_ltr <= 1'b1; m_next_ltr <= 1'b1; m_bonus <= 1'b0;
        end else begin
            m_bonus <= 1'b0;
            if (!bus.playGame) begin
                m_mode <= 0; m_frames <= 0; m_next_ltr <= 1'b1;
            end else begin
                case (m_mode)
                    0: if (bus.startOfFrame) begin
                        if (m_frames + 1 == SPN) begin
                            m_mode <= 1; m_frames <= 0;
                            m_ltr <= m_next_ltr;
                            m_next_ltr <= !m_next_ltr;
                            m_x <= m_next_ltr ? -W : SCR;
                        end else m_frames <= m_frames + 1;
                    end
                    1: if (bus.collision) begin
                        m_mode <= 2; m_bonus <= 1'b1;
                    end else if (bus.startOfFrame) begin
                        m_x <= m_nx;
                        if (m_ltr ? (m_nx >= SCR) : (m_nx <= -W)) m_mode <= 0;
                    end
                    2: if (bus.startOfFrame) begin
                        if (m_frames + 1 == HF) begin
                            m_mode <= 0; m_frames <= 0;
                        end else m_frames <= m_frames + 1;
                    end
                    default: m_mode <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_active", int'(bus.shipActive), int'(m_mode == 1));
        check("cyc_bonus", int'(bus.bonusHit), int'(m_bonus));
        check("cyc_inside", int'(bus.InsideRectangle), int'(m_inside));
        if (m_inside && bus.InsideRectangle) begin
            check("cyc_offx", int'(bus.offsetX), (int'(bus.pixelX) - m_x) & 11'h7ff);
            check("cyc_offy", int'(bus.offsetY), int'(bus.pixelY) - TY);
        end
        if (bus.bonusHit) n_bonus <= n_bonus + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof(input int n);
        for (int i = 0; i < n; i++) begin
            bus.startOfFrame = 1'b1;
            tick();
            bus.startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic probe(input string nm, input int px, input int py,
                         input int e_in, input int e_ox, input int e_oy);
        tick();
        bus.pixelX = 11'(px);
        bus.pixelY = 11'(py);
        #1;
        check({nm, "_in"}, int'(bus.InsideRectangle), e_in);
        if (e_in == 1) begin
            check({nm, "_ox"}, int'(bus.offsetX), e_ox);
            check({nm, "_oy"}, int'(bus.offsetY), e_oy);
        end
    endtask

    initial begin
        resetN = 1'b0;
        bus.pixelX = '0;
        bus.pixelY = '0;
        bus.startOfFrame = 1'b0;
        bus.playGame = 1'b0;
        bus.collision = 1'b0;
        repeat (3) tick();
        check("rst_active", int'(bus.shipActive), 0);
        check("rst_bonus", int'(bus.bonusHit), 0);
        check("rst_inside", int'(bus.InsideRectangle), 0);
        resetN = 1'b1;
        bus.playGame = 1'b1;
        tick();

        // first spawn, left-to-right from -64
        sof(SPN - 1);
        check("pre_spawn", int'(bus.shipActive), 0);
        sof(1);
        check("spawn1_active", int'(bus.shipActive), 1);
        check("spawn1_pos", int'(dut.r_pos), -64);
        sof(1);
        probe("ltr_first", 0, 50, 1, 62, 10);

        // reach 100 and probe the box edges
        sof(81);
        probe("p130", 130, 50, 1, 30, 10);
        probe("p164", 164, 50, 0, 0, 0);
        probe("p163", 163, 71, 1, 63, 31);
        probe("p100", 100, 40, 1, 0, 0);
        probe("p99", 99, 40, 0, 0, 0);
        probe("py72", 130, 72, 0, 0, 0);
        probe("py39", 130, 39, 0, 0, 0);

        // fly off the right edge
        sof(269);
        check("at638_active", int'(bus.shipActive), 1);
        sof(1);
        check("exit_active", int'(bus.shipActive), 0);
        check("exit_nobonus", n_bonus, 0);

        // second spawn, right-to-left from 640
        sof(SPN);
        check("spawn2_active", int'(bus.shipActive), 1);
        sof(1);
        probe("rtl_first", 639, 40, 1, 1, 0);
        probe("rtl_637", 637, 40, 0, 0, 0);

        // hit at 200 with a coincident frame pulse
        sof(219);
        bus.startOfFrame = 1'b1;
        bus.collision = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        bus.collision = 1'b0;
        check("hit_bonus", int'(bus.bonusHit), 1);
        check("hit_active", int'(bus.shipActive), 0);
        check("hit_pos", int'(dut.r_pos), 200);
        tick();
        check("hit_bonus_off", int'(bus.bonusHit), 0);
        bus.collision = 1'b1;
        tick();
        bus.collision = 1'b0;
        tick();
        check("hit_ignore_coll", n_bonus, 1);
        sof(HF);
        sof(SPN - 1);
        check("after_hit_idle", int'(bus.shipActive), 0);
        sof(1);
        check("spawn3_active", int'(bus.shipActive), 1);
        sof(1);
        probe("spawn3_ltr", 0, 50, 1, 62, 10);

        // drop playGame mid-flight
        bus.playGame = 1'b0;
        tick();
        check("drop_active", int'(bus.shipActive), 0);
        probe("drop_inside", 0, 50, 0, 0, 0);
        bus.collision = 1'b1;
        tick();
        bus.collision = 1'b0;
        tick();
        check("idle_ignore_coll", n_bonus, 1);
        bus.playGame = 1'b1;
        sof(SPN);
        check("spawn4_active", int'(bus.shipActive), 1);
        sof(1);
        probe("spawn4_ltr", 0, 50, 1, 62, 10);

        // reset asserted during HIT
        bus.collision = 1'b1;
        tick();
        bus.collision = 1'b0;
        check("hit2_bonus", int'(bus.bonusHit), 1);
        sof(5);
        #2;
        resetN = 1'b0;
        #1;
        check("rst_hit_active", int'(bus.shipActive), 0);
        check("rst_hit_bonus", int'(bus.bonusHit), 0);
        check("rst_hit_inside", int'(bus.InsideRectangle), 0);
        tick();
        resetN = 1'b1;
        sof(SPN - 1);
        check("rst_cnt_clear", int'(bus.shipActive), 0);
        sof(1);
        check("spawn5_active", int'(bus.shipActive), 1);
        sof(1);
        probe("spawn5_ltr", 0, 50, 1, 62, 10);
        check("total_bonus", n_bonus, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
